osd_frame_loader: RTL and testbench
===================================

// Module: osd_frame_loader
// PURPOSE
//  Input stage ahead of the OSD-2 decoder top. Accepts a stream of signed channel LLRs, one per beat.
//  Each sample is quantised to BIT_WIDTH with shift and saturation. N samples are assembled into a frame.
//  A frame is presented as y[N*BIT_WIDTH-1:0] with a 1-cycle valid pulse; y is held until the decoder's valid_out.
//  Ping-pong banks let frame k+1 fill while frame k is being decoded.
// PARAMETERS
//  N          64   codeword length (samples per frame)
//  BIT_WIDTH  4    quantised LLR width, two's complement
//  IN_W       8    input LLR width, two's complement
//  SHIFT      4    arithmetic right shift applied before saturation
//  IDX_W      $clog2(N)  sample-index width
// PORTS
//  clk        in   1               clock
//  rst_n      in   1               reset (one clock; reset is asynchronous and active-low)
//  s_valid    in   1               input beat valid
//  s_ready    out  1               loader can accept a beat
//  s_data     in   IN_W            signed LLR
//  s_last     in   1               marks the last sample of a frame
//  dec_done   in   1               decoder valid_out pulse; releases the bank being decoded
//  y          out  N*BIT_WIDTH     frame to decoder; sample i at [i*BIT_WIDTH +: BIT_WIDTH]
//  valid      out  1               1-cycle pulse: new frame on y
//  frame_err  out  1               1-cycle pulse: s_last mismatch
//  frame_cnt  out  16              frames issued (STATS build only)
//  err_cnt    out  16              frame_err events (STATS build only)
// BEHAVIOUR
//  Reset: both banks EMPTY, wr_bank=0, wr_idx=0. s_ready=0 while rst_n low, 1 after.
//   valid=0, frame_err=0, y=0, counters=0.
//  Beat: accepted when s_valid&s_ready. q=sat(s_data>>>SHIFT) to [-2^(BW-1), 2^(BW-1)-1].
//   q is written to bank[wr_bank][wr_idx]; wr_idx++.
//  Bank states: EMPTY -> FILL (first beat) -> FULL (Nth beat) -> BUSY (issued) -> EMPTY (dec_done).
//  Frame close: on the beat with wr_idx==N-1, regardless of s_last.
//   If s_last=0 on that beat, frame_err pulses next cycle and the frame is still kept.
//   On close, wr_bank toggles and wr_idx returns to 0.
//  Early s_last (wr_idx<N-1): partial frame is discarded and frame_err pulses. wr_idx returns to 0 in the same bank.
//  s_ready=0 when the target bank is FULL or BUSY (both banks occupied).
//  Issue: when no bank is BUSY and one is FULL, registered y is loaded from it.
//   valid pulses in the same cycle y first shows the frame; that bank goes BUSY.
//   Latency is 1 cycle from the closing beat when the decoder is idle.
//  Issue order matches fill order; the older FULL bank goes first.
//  y stays stable from valid until the cycle after dec_done.
//  dec_done with no BUSY bank is ignored. valid is never re-pulsed for the same frame.
//  dec_done and a FULL bank in the same cycle: release now, issue next cycle (valid no earlier than dec_done+1).
//  dec_done and the closing beat in the same cycle: both take effect. Next issue is on the following cycle.
//  rst_n low mid-frame or mid-decode: all state is cleared asynchronously. In-flight frames are lost.
//  Counters wrap at 2^16.
// CONFIGURATION
//  `OSD_LOADER_STATS_EN defined: frame_cnt increments on each valid; err_cnt increments on each frame_err.
//  Macro undefined: frame_cnt and err_cnt are tied to 0 and no counter flops exist. Ports are present in both builds.
// STRUCTURE
//  osd_pkg: sat_quant function (shift+saturate), bank-state encoding (EMPTY/FILL/FULL/BUSY), default N/BIT_WIDTH.
//  Sub-module llr_quantizer (combinational, IN_W->BIT_WIDTH) is instantiated once on s_data.
// TESTING
//  1) 64 beats of s_data=+8'sd32, s_last on beat 63, dec_done idle:
//     valid 1 cycle after the last beat; every y nibble = 4'sd2.
//  2) s_data=+127 / -128 / -1:
//     quantised to +7 / -8 / -1 (saturation and arithmetic shift).
//  3) Hold dec_done low and stream 3 frames:
//     s_ready drops after frame 2 closes; y keeps frame 1.
//     dec_done -> frame 2 issued 1 cycle later; s_ready returns.
//  4) s_last on beat 9:
//     frame_err pulse, no valid; next 64 beats give a clean frame and valid.
//  5) 64 beats with no s_last:
//     frame_err pulse and valid both occur; err_cnt=1 in the STATS build, 0 otherwise.
//  6) rst_n low on beat 30 of frame 2 while frame 1 is BUSY:
//     y=0, valid=0; after release a full frame issues normally.

Source files
------------

// File: rtl/osd_pkg.sv
// osd_pkg: shared definitions for the OSD-2 frame loader.
// Holds the default frame geometry, the ping-pong bank state encoding and the
// shift-and-saturate quantisation helper used on incoming channel LLRs.
package osd_pkg;

   // Default frame geometry and input format
   localparam int DEF_N         = 64;
   localparam int DEF_BIT_WIDTH = 4;
   localparam int DEF_IN_W      = 8;
   localparam int DEF_SHIFT     = 4;

   // Life cycle of one ping-pong bank: filled by the input stream, then handed
   // to the decoder, then released by the decoder's valid_out
   typedef enum logic [1:0] {
      BANK_EMPTY = 2'd0,
      BANK_FILL  = 2'd1,
      BANK_FULL  = 2'd2,
      BANK_BUSY  = 2'd3
   } bank_state_t;

   // Arithmetic right shift followed by saturation to a bw-bit two's complement
   // range. Works on a sign-extended 32-bit value so callers of any width share it.
   function automatic logic signed [31:0] sat_quant(
      input logic signed [31:0] x,
      input int unsigned        shift,
      input int unsigned        bw
   );
      logic signed [31:0] shifted;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      shifted = x >>> shift;
      hi      = (32'sd1 <<< (bw - 1)) - 32'sd1;
      lo      = -(32'sd1 <<< (bw - 1));
      if (shifted > hi) begin
         sat_quant = hi;
      end else if (shifted < lo) begin
         sat_quant = lo;
      end else begin
         sat_quant = shifted;
      end
   endfunction

endpackage

// File: rtl/osd_frame_loader_quantizer.sv
// llr_quantizer: combinational IN_W -> BIT_WIDTH LLR quantiser.
// Sign-extends the input, shifts it right arithmetically by SHIFT and clamps
// the result to the signed BIT_WIDTH range.
module llr_quantizer
   import osd_pkg::*;
#(
   parameter int IN_W      = DEF_IN_W,
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int SHIFT     = DEF_SHIFT
) (
   input  logic [IN_W-1:0]      llr,
   output logic [BIT_WIDTH-1:0] q
);

   logic signed [31:0] llr_ext;

   // Sign-extend so the shared 32-bit helper sees the true signed value
   assign llr_ext = {{(32 - IN_W){llr[IN_W-1]}}, llr};

   // Narrowing to BIT_WIDTH is lossless because the helper already saturated
   assign q = BIT_WIDTH'(sat_quant(llr_ext, SHIFT, BIT_WIDTH));

endmodule

// File: rtl/osd_frame_loader.sv
// osd_frame_loader: input stage ahead of the OSD-2 decoder.
// Quantises one signed LLR per beat, assembles N samples into a frame inside two
// ping-pong banks and presents each completed frame on y with a one-cycle valid
// pulse; y holds until the next frame is issued after the decoder's dec_done.
// Build macro OSD_LOADER_STATS_EN enables the frame_cnt/err_cnt counters;
// without it both ports read zero and no counter flops are built.
module osd_frame_loader
   import osd_pkg::*;
#(
   parameter int N         = DEF_N,
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int IN_W      = DEF_IN_W,
   parameter int SHIFT     = DEF_SHIFT,
   parameter int IDX_W     = $clog2(N)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [IN_W-1:0]        s_data,
   input  logic                   s_last,
   input  logic                   dec_done,
   output logic [N*BIT_WIDTH-1:0] y,
   output logic                   valid,
   output logic                   frame_err,
   output logic [15:0]            frame_cnt,
   output logic [15:0]            err_cnt
);

   logic [BIT_WIDTH-1:0]   q;
   logic                   beat_fire;
   logic                   close_fire;
   logic                   any_busy;

   // Two sample banks, plus a flattened view of each for a one-shot load of y
   logic [BIT_WIDTH-1:0]   bank_mem  [2][N];
   logic [N*BIT_WIDTH-1:0] bank_flat [2];
   // The frame being closed this cycle: stored samples plus the incoming last one
   logic [N*BIT_WIDTH-1:0] close_frame;

   bank_state_t            state_reg  [2];
   bank_state_t            state_next [2];
   logic                   wr_bank_reg;
   logic                   wr_bank_next;
   logic                   rd_bank_reg;
   logic                   rd_bank_next;
   logic [IDX_W-1:0]       wr_idx_reg;
   logic [IDX_W-1:0]       wr_idx_next;
   logic [N*BIT_WIDTH-1:0] y_reg;
   logic [N*BIT_WIDTH-1:0] y_next;
   logic                   valid_reg;
   logic                   valid_next;
   logic                   frame_err_reg;
   logic                   frame_err_next;
   logic                   s_ready_reg;
   logic                   s_ready_next;

   llr_quantizer #(
      .IN_W      (IN_W),
      .BIT_WIDTH (BIT_WIDTH),
      .SHIFT     (SHIFT)
   ) u_quant (
      .llr (s_data),
      .q   (q)
   );

   assign beat_fire  = s_valid & s_ready_reg;
   assign close_fire = beat_fire && (wr_idx_reg == IDX_W'(N - 1));
   assign any_busy   = (state_reg[0] == BANK_BUSY) || (state_reg[1] == BANK_BUSY);

   genvar gi;
   genvar gj;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         // Sample store: only the bank currently being filled takes the beat
         always_ff @(posedge clk) begin
            if (beat_fire && (wr_bank_reg == 1'(gi))) begin
               bank_mem[gi][wr_idx_reg] <= q;
            end
         end

         for (gj = 0; gj < N; gj++) begin : g_flat
            assign bank_flat[gi][gj*BIT_WIDTH +: BIT_WIDTH] = bank_mem[gi][gj];
         end
      end

      // The closing sample has not reached the bank yet, so splice it in from q
      for (gj = 0; gj < N; gj++) begin : g_close
         if (gj == N - 1) begin : g_last
            assign close_frame[gj*BIT_WIDTH +: BIT_WIDTH] = q;
         end else begin : g_stored
            assign close_frame[gj*BIT_WIDTH +: BIT_WIDTH] =
               wr_bank_reg ? bank_mem[1][gj] : bank_mem[0][gj];
         end
      end
   endgenerate

   // Next-state for the bank FSMs, write pointer, issue pointer and outputs
   always_comb begin
      state_next[0]  = state_reg[0];
      state_next[1]  = state_reg[1];
      wr_bank_next   = wr_bank_reg;
      rd_bank_next   = rd_bank_reg;
      wr_idx_next    = wr_idx_reg;
      y_next         = y_reg;
      valid_next     = 1'b0;
      frame_err_next = 1'b0;

      // Decoder finished: free the bank it was reading. Ignored when nothing is busy.
      if (dec_done) begin
         for (int b = 0; b < 2; b++) begin
            if (state_reg[b] == BANK_BUSY) begin
               state_next[b] = BANK_EMPTY;
            end
         end
      end

      // Input beat: close on the Nth sample regardless of s_last, drop on early s_last
      if (beat_fire) begin
         if (close_fire) begin
            state_next[wr_bank_reg] = BANK_FULL;
            wr_bank_next            = ~wr_bank_reg;
            wr_idx_next             = '0;
            frame_err_next          = ~s_last;
         end else if (s_last) begin
            state_next[wr_bank_reg] = BANK_EMPTY;
            wr_idx_next             = '0;
            frame_err_next          = 1'b1;
         end else begin
            state_next[wr_bank_reg] = BANK_FILL;
            wr_idx_next             = wr_idx_reg + 1'b1;
         end
      end

      // Issue uses this cycle's busy status, so a release only enables an issue
      // on the following cycle. A frame closing into an idle decoder goes straight out.
      if (!any_busy) begin
         if (state_reg[rd_bank_reg] == BANK_FULL) begin
            state_next[rd_bank_reg] = BANK_BUSY;
            y_next                  = bank_flat[rd_bank_reg];
            valid_next              = 1'b1;
            rd_bank_next            = ~rd_bank_reg;
         end else if (close_fire && (wr_bank_reg == rd_bank_reg)) begin
            state_next[wr_bank_reg] = BANK_BUSY;
            y_next                  = close_frame;
            valid_next              = 1'b1;
            rd_bank_next            = ~rd_bank_reg;
         end
      end

      // Accept beats only while the bank we would write is free or part-filled
      s_ready_next = (state_next[wr_bank_next] == BANK_EMPTY) ||
                     (state_next[wr_bank_next] == BANK_FILL);
   end

   // Control and output registers; reset drops any in-flight frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg[0]  <= BANK_EMPTY;
         state_reg[1]  <= BANK_EMPTY;
         wr_bank_reg   <= 1'b0;
         rd_bank_reg   <= 1'b0;
         wr_idx_reg    <= '0;
         y_reg         <= '0;
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
         s_ready_reg   <= 1'b0;
      end else begin
         state_reg[0]  <= state_next[0];
         state_reg[1]  <= state_next[1];
         wr_bank_reg   <= wr_bank_next;
         rd_bank_reg   <= rd_bank_next;
         wr_idx_reg    <= wr_idx_next;
         y_reg         <= y_next;
         valid_reg     <= valid_next;
         frame_err_reg <= frame_err_next;
         s_ready_reg   <= s_ready_next;
      end
   end

   assign y         = y_reg;
   assign valid     = valid_reg;
   assign frame_err = frame_err_reg;
   assign s_ready   = s_ready_reg;

`ifdef OSD_LOADER_STATS_EN
   logic [15:0] frame_cnt_reg;
   logic [15:0] err_cnt_reg;

   // Event counters, updated alongside the valid/frame_err pulses; wrap at 2^16
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_reg <= '0;
         err_cnt_reg   <= '0;
      end else begin
         if (valid_next) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
         end
         if (frame_err_next) begin
            err_cnt_reg <= err_cnt_reg + 16'd1;
         end
      end
   end

   assign frame_cnt = frame_cnt_reg;
   assign err_cnt   = err_cnt_reg;
`else
   assign frame_cnt = 16'd0;
   assign err_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_osd_frame_loader.sv
// tb_osd_frame_loader: scoreboard bench for osd_frame_loader.
// Stimulus pushes expected frames / error events into queues; a monitor pops
// them whenever valid or frame_err is seen. Directed checks cover reset,
// latency, quantisation boundaries, back-pressure and asynchronous reset.
module tb_osd_frame_loader;

   localparam int N    = 64;
   localparam int BW   = 4;
   localparam int IN_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              s_valid;
   logic              s_ready;
   logic [IN_W-1:0]   s_data;
   logic              s_last;
   logic              dec_done;
   logic [N*BW-1:0]   y;
   logic              valid;
   logic              frame_err;
   logic [15:0]       frame_cnt;
   logic [15:0]       err_cnt;

   int                checks = 0;
   int                errors = 0;
   logic [N*BW-1:0]   exp_q[$];
   int                err_pending = 0;
   logic [IN_W-1:0]   fdata [N];
   logic [N*BW-1:0]   frame_a;
   logic [N*BW-1:0]   frame_b;
   logic [N*BW-1:0]   frame_c;

   osd_frame_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .dec_done  (dec_done),
      .y         (y),
      .valid     (valid),
      .frame_err (frame_err),
      .frame_cnt (frame_cnt),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   // Reference quantiser: floor division by 16, then clamp to [-8, 7]
   function automatic logic [3:0] q_model(input logic [IN_W-1:0] d);
      int v;
      int s;
      v = int'($signed(d));
      if (v >= 0) s = v / 16;
      else        s = -((-v + 15) / 16);
      if (s > 7)  s = 7;
      if (s < -8) s = -8;
      return s[3:0];
   endfunction

   function automatic logic [N*BW-1:0] model_frame();
      logic [N*BW-1:0] f;
      for (int i = 0; i < N; i++) f[i*BW +: BW] = q_model(fdata[i]);
      return f;
   endfunction

   task automatic chk(input string name, input logic [N*BW-1:0] act, input logic [N*BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
      else $display("check %s ok: %0h", name, act);
   endtask

   // Drive one beat from a negedge, wait (bounded) for acceptance, return on a negedge
   task automatic send_beat(input logic [IN_W-1:0] d, input logic last);
      int n;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      n = 0;
      while (!s_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         checks++;
         errors++;
         $display("FAIL beat_wait: s_ready=%b after %0d cycles, required 1", s_ready, n);
      end else begin
         @(posedge clk);
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input int len, input int last_pos);
      for (int i = 0; i < len; i++) send_beat(fdata[i], (i == last_pos));
      $display("sent %0d beats, s_last at %0d", len, last_pos);
   endtask

   task automatic pulse_done();
      dec_done = 1'b1;
      @(negedge clk);
      dec_done = 1'b0;
   endtask

   // Scoreboard monitor: pop an expected frame on valid, an expected error on frame_err
   initial begin
      logic [N*BW-1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (valid === 1'b1) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_valid: unexpected valid with y=%0h, required no frame", y);
               end else begin
                  e = exp_q.pop_front();
                  if (y !== e) begin
                     errors++;
                     $display("FAIL sb_frame: y=%0h required %0h", y, e);
                  end else $display("frame ok: %0h", y);
               end
            end
            if (frame_err === 1'b1) begin
               checks++;
               if (err_pending == 0) begin
                  errors++;
                  $display("FAIL sb_err: frame_err=1 with none pending, required 0");
               end else begin
                  err_pending--;
                  $display("frame_err ok");
               end
            end
         end
      end
   end

   // Watchdog: the run must terminate by itself
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b1;
      s_valid  = 1'b0;
      s_data   = '0;
      s_last   = 1'b0;
      dec_done = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_s_ready",   s_ready,   0);
      chk("rst_valid",     valid,     0);
      chk("rst_y",         y,         0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_err_cnt",   err_cnt,   0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_s_ready", s_ready, 1);

      // 1) constant +32 -> every nibble 2, valid on the cycle after the closing beat
      for (int i = 0; i < N; i++) fdata[i] = 8'd32;
      frame_a = model_frame();
      exp_q.push_back(frame_a);
      send_frame(N, N - 1);
      chk("t1_latency_valid", valid, 1);
      chk("t1_y_all_2", y, {N{4'h2}});
      chk("t1_no_err", frame_err, 0);
      pulse_done();
      repeat (2) @(negedge clk);

      // 2) quantisation boundaries
      for (int i = 0; i < N; i++) fdata[i] = 8'(i * 4 + 156);
      fdata[0] = 8'h7F;  fdata[1] = 8'h80;  fdata[2] = 8'hFF;
      fdata[3] = 8'h0F;  fdata[4] = 8'h10;  fdata[5] = 8'hF0;  fdata[6] = 8'hEF;
      exp_q.push_back(model_frame());
      send_frame(N, N - 1);
      chk("t2_valid", valid, 1);
      chk("t2_nibbles_0_6", y[27:0], 28'hEF10F87);
      pulse_done();
      repeat (2) @(negedge clk);

      // 3) decoder stalled across three frames
      for (int i = 0; i < N; i++) fdata[i] = 8'(i);
      frame_a = model_frame();
      exp_q.push_back(frame_a);
      send_frame(N, N - 1);
      chk("t3_a_valid", valid, 1);
      for (int i = 0; i < N; i++) fdata[i] = 8'(8'hA0 + i);
      frame_b = model_frame();
      exp_q.push_back(frame_b);
      send_frame(N, N - 1);
      chk("t3_ready_drop", s_ready, 0);
      chk("t3_b_no_valid", valid, 0);
      for (int i = 0; i < N; i++) fdata[i] = 8'(8'h70 - i * 2);
      frame_c = model_frame();
      exp_q.push_back(frame_c);
      fork
         send_frame(N, N - 1);
         begin
            repeat (3) @(negedge clk);
            chk("t3_ready_held_low", s_ready, 0);
            chk("t3_y_holds_a", y, frame_a);
            dec_done = 1'b1;
            @(negedge clk);
            dec_done = 1'b0;
            chk("t3_ready_back", s_ready, 1);
            chk("t3_no_early_valid", valid, 0);
            @(negedge clk);
            chk("t3_b_valid", valid, 1);
            chk("t3_y_is_b", y, frame_b);
         end
      join
      repeat (2) @(negedge clk);
      chk("t3_y_still_b", y, frame_b);
      pulse_done();
      @(negedge clk);
      chk("t3_c_valid", valid, 1);
      chk("t3_y_is_c", y, frame_c);
      pulse_done();
      repeat (2) @(negedge clk);

      // 4) early s_last on beat 9 discards the partial frame
      for (int i = 0; i < N; i++) fdata[i] = 8'h55;
      err_pending++;
      send_frame(10, 9);
      chk("t4_err_pulse", frame_err, 1);
      chk("t4_no_valid", valid, 0);
      for (int i = 0; i < N; i++) fdata[i] = 8'(i * 2);
      exp_q.push_back(model_frame());
      send_frame(N, N - 1);
      chk("t4_clean_valid", valid, 1);
      chk("t4_clean_no_err", frame_err, 0);
      pulse_done();
      repeat (2) @(negedge clk);

      // 5) fresh reset, then 64 beats without s_last: kept frame plus error
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) fdata[i] = 8'hC0;
      exp_q.push_back(model_frame());
      err_pending++;
      send_frame(N, -1);
      chk("t5_err_pulse", frame_err, 1);
      chk("t5_valid", valid, 1);
      chk("t5_y_all_c", y, {N{4'hC}});
`ifdef OSD_LOADER_STATS_EN
      chk("t5_err_cnt", err_cnt, 1);
      chk("t5_frame_cnt", frame_cnt, 1);
`else
      chk("t5_err_cnt", err_cnt, 0);
      chk("t5_frame_cnt", frame_cnt, 0);
`endif
      pulse_done();
      repeat (2) @(negedge clk);

      // 6) asynchronous reset mid-frame while a frame is busy
      for (int i = 0; i < N; i++) fdata[i] = 8'h50;
      exp_q.push_back(model_frame());
      send_frame(N, N - 1);
      chk("t6_f1_valid", valid, 1);
      for (int i = 0; i < N; i++) fdata[i] = 8'h23;
      send_frame(30, -1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_y", y, 0);
      chk("t6_rst_valid", valid, 0);
      chk("t6_rst_ready", s_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_rel_ready", s_ready, 1);
      for (int i = 0; i < N; i++) fdata[i] = 8'hB0;
      exp_q.push_back(model_frame());
      send_frame(N, N - 1);
      chk("t6_f3_valid", valid, 1);
      chk("t6_y_all_b", y, {N{4'hB}});
      pulse_done();
      repeat (4) @(negedge clk);

      chk("end_frames_drained", exp_q.size(), 0);
      chk("end_errs_drained", err_pending, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
